encoder32to5_drain: RTL

//  Sequential 32-to-5 encoder; inverse of the 5-to-32 decoder tree.
//  - Accepts a 32-bit request word over a valid/ready handshake.
//  - Emits the 5-bit index of every set bit, one index per cycle, until the word is exhausted.
//  - Sits between request/interrupt collectors and consumers of binary indices.

---
 rtl/encoder32to5_drain.sv | 76 +++++++
 1 files changed

// File: rtl/encoder32to5_drain.sv
// Sequential 32-to-5 encoder: accepts a request word, then emits the index of each set bit, one per cycle.
// Optional build macro ENC32_MSB_FIRST_EN selects MSB-first drain order (default LSB-first).
module encoder32to5_drain #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_idx,
  output logic             out_last,
  output logic             zero_word,
  output logic [CNT_W-1:0] words_done
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] mask;
  logic        accept;
  logic        xfer;

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DRAIN);
    accept    = in_valid && in_ready;
    xfer      = out_valid && out_ready;
  end

  // Priority encode: the last matching iteration wins, so loop order picks the end.
  always_comb begin
    out_idx = '0;
`ifdef ENC32_MSB_FIRST_EN
    for (int unsigned i = 0; i < 32; i++) begin
      if (mask[i]) out_idx = 5'(i);
    end
`else
    for (int unsigned i = 0; i < 32; i++) begin
      if (mask[31 - i]) out_idx = 5'(31 - i);
    end
`endif
  end

  always_comb out_last = (mask != '0) && ((mask & (mask - 32'd1)) == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (in_word != '0)) state_nxt = DRAIN;
      DRAIN:   if (xfer && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mask       <= '0;
      zero_word  <= 1'b0;
      words_done <= '0;
    end else begin
      state     <= state_nxt;
      zero_word <= accept && (in_word == '0);
      if (accept && (in_word != '0)) begin
        mask <= in_word;
      end else if (xfer) begin
        mask <= mask & ~(32'd1 << out_idx);
      end
      if (xfer && out_last) words_done <= words_done + 1'b1;
    end
  end

endmodule
